// File: rtl/uart_pkt_controller.sv
// uart_pkt_controller: frames UART bytes into sync/addr/len/payload/xor-checksum packets
// and streams payload bytes to an external buffer.
module uart_pkt_controller #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int        CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_complete,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [7:0]    buf_wdata,
  output logic [7:0]    pkt_addr,
  output logic [7:0]    pkt_len,
  output logic          pkt_valid,
  output logic          pkt_error,
  output logic [1:0]    err_code,
  output logic          busy
);
  typedef enum logic [2:0] {SYNC, ADDR, LEN, PAYLOAD, CHECK} state_t;
  state_t        state;
  logic          s1, s2, s3, primed, armed;
  logic [7:0]    csum, idx;
  logic [CW-1:0] cnt;
  logic          byte_stb;
  // armed only after a genuine low is seen, so a level already high at reset release is ignored
  assign byte_stb = s2 & ~s3 & armed;
  assign busy     = (state != SYNC);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      primed <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1 <= rx_complete;
      s2 <= s1;
      s3 <= s2;
      primed <= 1'b1;
      armed <= armed | (primed & ~s1);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SYNC;
      buf_we <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      pkt_addr <= '0;
      pkt_len <= '0;
      pkt_valid <= 1'b0;
      pkt_error <= 1'b0;
      err_code <= '0;
      csum <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      buf_we <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_error <= 1'b0;
      if (byte_stb) begin
        cnt <= '0;
        case (state)
          SYNC: if (rx_data == SYNC_BYTE) begin
            state <= ADDR;
            csum <= '0;
          end
          ADDR: begin
            pkt_addr <= rx_data;
            csum <= csum ^ rx_data;
            state <= LEN;
          end
          LEN: begin
            pkt_len <= rx_data;
            csum <= csum ^ rx_data;
            idx <= '0;
            if (32'(rx_data) > MAX_LEN) begin
              pkt_error <= 1'b1;
              err_code <= 2'd1;
              state <= SYNC;
            end else state <= (rx_data == 8'd0) ? CHECK : PAYLOAD;
          end
          PAYLOAD: begin
            buf_we <= 1'b1;
            buf_waddr <= idx[AW-1:0];
            buf_wdata <= rx_data;
            csum <= csum ^ rx_data;
            idx <= idx + 8'd1;
            if (idx + 8'd1 == pkt_len) state <= CHECK;
          end
          CHECK: begin
            if (rx_data == csum) pkt_valid <= 1'b1;
            else begin
              pkt_error <= 1'b1;
              err_code <= 2'd2;
            end
            state <= SYNC;
          end
          default: state <= SYNC;
        endcase
      end else if (state == SYNC) cnt <= '0;
      else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        pkt_error <= 1'b1;
        err_code <= 2'd3;
        state <= SYNC;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: doc/uart_pkt_controller.md
UART_PKT_CONTROLLER -- requirements
Module: uart_pkt_controller

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, packet start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes (1..256).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rx_data  input  8  received byte from UART receiver, stable while rx_complete high.
REQ-007 SHALL have port rx_complete  input  1  receiver byte-done level, asynchronous to clk, high for at least 3 clk cycles.
REQ-008 SHALL have port buf_we  output  1  payload buffer write strobe.
REQ-009 SHALL have port buf_waddr  output  $clog2(MAX_LEN) (min 1)  payload byte index.
REQ-010 SHALL have port buf_wdata  output  8  payload byte.
REQ-011 SHALL have port pkt_addr  output  8  address byte of the packet being or last received.
REQ-012 SHALL have port pkt_len  output  8  length byte of the packet being or last received.
REQ-013 SHALL have port pkt_valid  output  1  one-cycle pulse, packet accepted.
REQ-014 SHALL have port pkt_error  output  1  one-cycle pulse, packet rejected.
REQ-015 SHALL have port err_code  output  2  reason for last pkt_error: 1 length, 2 checksum, 3 timeout; holds until next error.
REQ-016 SHALL have port busy  output  1  high in any state other than SYNC.

Function
REQ-017 SHALL synchronise rx_complete through two flops and generate internal byte_stb, one clk cycle, on the rising edge of the synchronised signal; rx_data sampled in the byte_stb cycle.
REQ-018 SHALL implement states SYNC, ADDR, LEN, PAYLOAD, CHECK; packet format: SYNC_BYTE, addr, len, len payload bytes, checksum.
REQ-019 SYNC: byte_stb with rx_data==SYNC_BYTE -> ADDR, clear running checksum to 0; other bytes silently dropped.
REQ-020 ADDR: byte_stb -> latch pkt_addr, checksum ^= byte, -> LEN.
REQ-021 LEN: byte_stb -> latch pkt_len, checksum ^= byte; len>MAX_LEN -> pkt_error, err_code=1, -> SYNC; len==0 -> CHECK; else -> PAYLOAD, index=0.
REQ-022 PAYLOAD: each byte_stb -> buf_we=1 for that single cycle with buf_waddr=index, buf_wdata=byte; checksum ^= byte; index+1; after byte len-1 -> CHECK.
REQ-023 CHECK: byte_stb -> byte==checksum: pkt_valid; else pkt_error, err_code=2; -> SYNC either way.
REQ-024 buf_we, pkt_valid, pkt_error SHALL be registered and assert the clk cycle after the causing byte_stb.
REQ-025 Timeout counter SHALL reset on each byte_stb and on entering SYNC; reaching TIMEOUT_CYCLES in a non-SYNC state -> pkt_error, err_code=3, -> SYNC.
REQ-026 Timeout expiry coincident with byte_stb: byte_stb wins, byte processed, counter cleared.
REQ-027 pkt_valid and pkt_error SHALL never assert together; buf contents valid to consumer only after pkt_valid.
REQ-028 SYNC_BYTE appearing inside ADDR/LEN/PAYLOAD/CHECK SHALL be treated as data, no resynchronisation.

Reset
REQ-029 rst_n low SHALL asynchronously force state=SYNC, buf_we=0, buf_waddr=0, buf_wdata=0, pkt_addr=0, pkt_len=0, pkt_valid=0, pkt_error=0, err_code=0, busy=0, checksum=0, timeout counter=0, synchroniser flops=0.
REQ-030 Reset mid-packet SHALL discard the packet without pkt_error; first byte after release parsed in SYNC.
REQ-031 rx_complete high at reset release SHALL NOT generate byte_stb until it falls and rises again.

Verification
REQ-032 Bytes A5,10,03,11,22,33,checksum 10^03^11^22^33=13 -> buf writes (0,11),(1,22),(2,33), pkt_addr=10, pkt_len=03, one pkt_valid pulse.
REQ-033 Same packet with checksum 14 -> three buf writes, pkt_error, err_code=2, no pkt_valid.
REQ-034 A5,01,11 (len 17>16) -> pkt_error, err_code=1, no buf_we; following A5,02,00,02 -> pkt_valid.
REQ-035 A5,07 then silence TIMEOUT_CYCLES -> pkt_error, err_code=3, busy falls; garbage 00,FF,A5,01,00,01 -> pkt_valid only.
REQ-036 rst_n pulsed low after A5,10,02,AA -> all outputs at reset values, no pulse; subsequent valid packet accepted.
REQ-037 rx_complete held high 50 cycles -> exactly one byte_stb; A5,00,00,00 -> pkt_valid, no buf_we.
